// File: rtl/d_cache_mem_ctrl.sv
// Data-cache line mover: write-back and refill bursts between a cache and word-wide memory.
// Optional build macro D_CACHE_WB_REFILL_EN chains a victim writeback directly into a refill.
module d_cache_mem_ctrl #(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int LINE_WORDS       = 4,
    parameter int ENTRY_INDEX_SIZE = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic                       req_refill,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [ADDR_WIDTH-1:0]      req_wb_addr,
    input  logic [LINE_WORDS*LEN-1:0]  req_wdata,
    output logic                       resp_valid,
    output logic [LINE_WORDS*LEN-1:0]  resp_rdata,
    output logic [1:0]                 d_cache_mem_vis_signal,
    output logic [ADDR_WIDTH-1:0]      d_cache_mem_vis_addr,
    output logic [ENTRY_INDEX_SIZE-1:0] length,
    output logic [LEN-1:0]             writen_data,
    input  logic [LEN-1:0]             mem_data,
    input  logic [1:0]                 mem_status
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // WRITE | one MEM_WRITE beat per cycle, LINE_WORDS beats
    // READ  | one MEM_READ_BURST beat per cycle, LINE_WORDS beats
    // TAIL  | MEM_NOP while the last read word arrives
    // DONE  | resp_valid pulse, then back to IDLE

    localparam logic [1:0] MEM_NOP        = 2'b00;
    localparam logic [1:0] MEM_WRITE      = 2'b01;
    localparam logic [1:0] MEM_READ_BURST = 2'b10;

    localparam int BW  = $clog2(LINE_WORDS);
    localparam int OFF = BW + 2;
    localparam logic [BW-1:0]         LAST       = BW'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'((1 << OFF) - 1));

    typedef enum logic [2:0] {IDLE, WRITE, READ, TAIL, DONE} state_t;

    state_t                    state, state_nxt;
    logic [BW-1:0]             beat, beat_nxt;
    logic [ADDR_WIDTH-1:0]     wr_base, rd_base, beat_off;
    logic [LINE_WORDS*LEN-1:0] wline, stage, stage_nxt, rdata_q;
    logic                      do_refill;
    logic                      cap_en;
    logic [BW-1:0]             cap_idx;
    logic                      unused_ok;

    assign unused_ok  = ^{req_refill, req_wb_addr, mem_status};
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign resp_rdata = rdata_q;
    assign beat_off   = ADDR_WIDTH'({beat, 2'b00});

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        case (state)
            IDLE: begin
                beat_nxt = '0;
                if (req_valid) state_nxt = req_write ? WRITE : READ;
            end
            WRITE: begin
                if (beat == LAST) begin
                    beat_nxt  = '0;
                    state_nxt = do_refill ? READ : DONE;
                end else begin
                    beat_nxt = beat + 1'b1;
                end
            end
            READ: begin
                if (beat == LAST) begin
                    beat_nxt  = '0;
                    state_nxt = TAIL;
                end else begin
                    beat_nxt = beat + 1'b1;
                end
            end
            TAIL:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read word for beat k arrives one cycle after its address beat
    always_comb begin
        stage_nxt = stage;
        if (cap_en) stage_nxt[cap_idx*LEN +: LEN] = mem_data;
    end

    always_comb begin
        d_cache_mem_vis_signal = MEM_NOP;
        d_cache_mem_vis_addr   = '0;
        length                 = '0;
        writen_data            = '0;
        case (state)
            WRITE: begin
                d_cache_mem_vis_signal = MEM_WRITE;
                d_cache_mem_vis_addr   = wr_base + beat_off;
                length                 = ENTRY_INDEX_SIZE'(LINE_WORDS);
                writen_data            = wline[beat*LEN +: LEN];
            end
            READ: begin
                d_cache_mem_vis_signal = MEM_READ_BURST;
                d_cache_mem_vis_addr   = rd_base + beat_off;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            wr_base   <= '0;
            rd_base   <= '0;
            wline     <= '0;
            stage     <= '0;
            rdata_q   <= '0;
            do_refill <= 1'b0;
            cap_en    <= 1'b0;
            cap_idx   <= '0;
        end else begin
            state   <= state_nxt;
            beat    <= beat_nxt;
            stage   <= stage_nxt;
            cap_en  <= (state == READ);
            cap_idx <= beat;
            if (state == TAIL) rdata_q <= stage_nxt;
            if (state == IDLE && req_valid) begin
                wline   <= req_wdata;
                rd_base <= req_addr & ALIGN_MASK;
`ifdef D_CACHE_WB_REFILL_EN
                if (req_write && req_refill) begin
                    wr_base   <= req_wb_addr & ALIGN_MASK;
                    do_refill <= 1'b1;
                end else begin
                    wr_base   <= req_addr & ALIGN_MASK;
                    do_refill <= 1'b0;
                end
`else
                wr_base   <= req_addr & ALIGN_MASK;
                do_refill <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_d_cache_mem_ctrl.sv
// Directed bench for d_cache_mem_ctrl with a behavioural word memory.
// Honours D_CACHE_WB_REFILL_EN for the writeback+refill scenario.
module tb_d_cache_mem_ctrl;

    localparam logic [1:0] MEM_NOP        = 2'b00;
    localparam logic [1:0] MEM_WRITE      = 2'b01;
    localparam logic [1:0] MEM_READ_BURST = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic         req_refill = 1'b0;
    logic [16:0]  req_addr = '0;
    logic [16:0]  req_wb_addr = '0;
    logic [127:0] req_wdata = '0;
    logic         resp_valid;
    logic [127:0] resp_rdata;
    logic [1:0]   vis_signal;
    logic [16:0]  vis_addr;
    logic [2:0]   length;
    logic [31:0]  writen_data;
    logic [31:0]  mem_data = '0;
    logic [1:0]   mem_status = 2'b00;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0]   sig_log [0:31];
    logic [16:0]  adr_log [0:31];
    logic [2:0]   len_log [0:31];
    logic [31:0]  wd_log  [0:31];
    logic         rv_log  [0:31];
    logic         rdy_log [0:31];
    logic [127:0] rd_log  [0:31];

    d_cache_mem_ctrl dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_write              (req_write),
        .req_refill             (req_refill),
        .req_addr               (req_addr),
        .req_wb_addr            (req_wb_addr),
        .req_wdata              (req_wdata),
        .resp_valid             (resp_valid),
        .resp_rdata             (resp_rdata),
        .d_cache_mem_vis_signal (vis_signal),
        .d_cache_mem_vis_addr   (vis_addr),
        .length                 (length),
        .writen_data            (writen_data),
        .mem_data               (mem_data),
        .mem_status             (mem_status)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [16:0] a);
        case (a)
            17'h00100: return 32'h11;
            17'h00104: return 32'h22;
            17'h00108: return 32'h33;
            17'h0010C: return 32'h44;
            default:   return {8'hD0, 7'd0, a};
        endcase
    endfunction

    function automatic logic [127:0] line_of(input logic [16:0] b);
        return {mem_word(17'(b + 17'd12)), mem_word(17'(b + 17'd8)),
                mem_word(17'(b + 17'd4)), mem_word(b)};
    endfunction

    // Memory answers one cycle after each read beat; junk otherwise
    always @(posedge clk) begin
        if (vis_signal == MEM_READ_BURST) mem_data <= mem_word(vis_addr);
        else                              mem_data <= 32'hDEAD_BEEF;
    end

    task automatic record(input int i);
        sig_log[i] = vis_signal;
        adr_log[i] = vis_addr;
        len_log[i] = length;
        wd_log[i]  = writen_data;
        rv_log[i]  = resp_valid;
        rdy_log[i] = req_ready;
        rd_log[i]  = resp_rdata;
    endtask

    // Presents one request; log index i is the i-th cycle after the accept edge
    task automatic run_txn(input logic w, input logic rf, input logic [16:0] a,
                           input logic [16:0] wa, input logic [127:0] wd,
                           input bit hold, input int n);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_refill = rf;
        req_addr = a; req_wb_addr = wa; req_wdata = wd;
        record(0);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            record(i);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rv got %b want 0", resp_valid); end
        vectors++; if (resp_rdata !== 128'd0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
        vectors++; if (vis_signal !== MEM_NOP) begin miscompares++; $display("FAIL reset_sig got %b want %b", vis_signal, MEM_NOP); end
        vectors++; if ({vis_addr, length, writen_data} !== 52'd0) begin miscompares++; $display("FAIL reset_outs got %h/%h/%h want 0", vis_addr, length, writen_data); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle got rdy=%b rv=%b want 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_refill;
        int pulses = 0;
        run_txn(1'b0, 1'b0, 17'h00104, 17'h0, 128'h0, 1'b0, 8);
        vectors++; if (rdy_log[0] !== 1'b1) begin miscompares++; $display("FAIL refill_ready_pre got %b want 1", rdy_log[0]); end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (sig_log[k+1] !== MEM_READ_BURST || adr_log[k+1] !== 17'(17'h100 + 4*k)) begin
                miscompares++;
                $display("FAIL refill_beat%0d got sig=%b addr=%h want %b/%h", k, sig_log[k+1], adr_log[k+1], MEM_READ_BURST, 17'(17'h100 + 4*k));
            end
        end
        vectors++; if (sig_log[5] !== MEM_NOP || adr_log[5] !== 17'h0) begin miscompares++; $display("FAIL refill_tail got sig=%b addr=%h want 00/0", sig_log[5], adr_log[5]); end
        vectors++; if (rdy_log[3] !== 1'b0) begin miscompares++; $display("FAIL refill_busy got %b want 0", rdy_log[3]); end
        for (int i = 1; i <= 8; i++) pulses += int'(rv_log[i]);
        vectors++; if (rv_log[6] !== 1'b1 || pulses != 1) begin miscompares++; $display("FAIL refill_rv got rv6=%b pulses=%0d want 1/1", rv_log[6], pulses); end
        vectors++; if (rd_log[6] !== 128'h00000044_00000033_00000022_00000011) begin miscompares++; $display("FAIL refill_rdata got %h want %h", rd_log[6], 128'h00000044_00000033_00000022_00000011); end
        vectors++; if (rd_log[8] !== 128'h00000044_00000033_00000022_00000011) begin miscompares++; $display("FAIL refill_rdata_hold got %h", rd_log[8]); end
        vectors++; if (rdy_log[7] !== 1'b1) begin miscompares++; $display("FAIL refill_ready_post got %b want 1", rdy_log[7]); end
    endtask

    task automatic test_write_only;
        int pulses = 0;
        run_txn(1'b1, 1'b0, 17'h00200, 17'h0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0, 8);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (sig_log[k+1] !== MEM_WRITE || adr_log[k+1] !== 17'(17'h200 + 4*k) ||
                len_log[k+1] !== 3'd4 || wd_log[k+1] !== 32'(32'hA0 + k)) begin
                miscompares++;
                $display("FAIL write_beat%0d got sig=%b addr=%h len=%0d wd=%h want %b/%h/4/%h", k, sig_log[k+1], adr_log[k+1], len_log[k+1], wd_log[k+1], MEM_WRITE, 17'(17'h200 + 4*k), 32'(32'hA0 + k));
            end
        end
        vectors++; if (sig_log[5] !== MEM_NOP || len_log[5] !== 3'd0 || wd_log[5] !== 32'd0) begin miscompares++; $display("FAIL write_done_outs got sig=%b len=%0d wd=%h want 00/0/0", sig_log[5], len_log[5], wd_log[5]); end
        for (int i = 1; i <= 8; i++) pulses += int'(rv_log[i]);
        vectors++; if (rv_log[5] !== 1'b1 || pulses != 1) begin miscompares++; $display("FAIL write_rv got rv5=%b pulses=%0d want 1/1", rv_log[5], pulses); end
        vectors++; if (rd_log[6] !== line_of(17'h100)) begin miscompares++; $display("FAIL write_rdata_kept got %h want %h", rd_log[6], line_of(17'h100)); end
    endtask

    task automatic test_wb_refill;
        int pulses = 0;
        run_txn(1'b1, 1'b1, 17'h00400, 17'h00300, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0, 11);
        for (int i = 1; i <= 11; i++) pulses += int'(rv_log[i]);
`ifdef D_CACHE_WB_REFILL_EN
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (sig_log[k+1] !== MEM_WRITE || adr_log[k+1] !== 17'(17'h300 + 4*k) || wd_log[k+1] !== 32'(32'hB0 + k)) begin
                miscompares++;
                $display("FAIL wbr_write%0d got sig=%b addr=%h wd=%h", k, sig_log[k+1], adr_log[k+1], wd_log[k+1]);
            end
            vectors++;
            if (sig_log[k+5] !== MEM_READ_BURST || adr_log[k+5] !== 17'(17'h400 + 4*k)) begin
                miscompares++;
                $display("FAIL wbr_read%0d got sig=%b addr=%h want %b/%h", k, sig_log[k+5], adr_log[k+5], MEM_READ_BURST, 17'(17'h400 + 4*k));
            end
        end
        vectors++; if (rv_log[10] !== 1'b1 || pulses != 1) begin miscompares++; $display("FAIL wbr_rv got rv10=%b pulses=%0d want 1/1", rv_log[10], pulses); end
        vectors++; if (rd_log[10] !== line_of(17'h400)) begin miscompares++; $display("FAIL wbr_rdata got %h want %h", rd_log[10], line_of(17'h400)); end
`else
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (sig_log[k+1] !== MEM_WRITE || adr_log[k+1] !== 17'(17'h400 + 4*k) || wd_log[k+1] !== 32'(32'hB0 + k)) begin
                miscompares++;
                $display("FAIL wbr_write%0d got sig=%b addr=%h wd=%h", k, sig_log[k+1], adr_log[k+1], wd_log[k+1]);
            end
        end
        vectors++; if (sig_log[5] !== MEM_NOP) begin miscompares++; $display("FAIL wbr_no_read got sig=%b want 00", sig_log[5]); end
        vectors++; if (rv_log[5] !== 1'b1 || pulses != 1) begin miscompares++; $display("FAIL wbr_rv got rv5=%b pulses=%0d want 1/1", rv_log[5], pulses); end
        vectors++; if (rd_log[6] !== line_of(17'h100)) begin miscompares++; $display("FAIL wbr_rdata_kept got %h want %h", rd_log[6], line_of(17'h100)); end
`endif
    endtask

    task automatic test_back_to_back;
        run_txn(1'b0, 1'b0, 17'h1FFF0, 17'h0, 128'h0, 1'b0, 6);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (adr_log[k+1] !== 17'(17'h1FFF0 + 4*k)) begin
                miscompares++;
                $display("FAIL wrap_beat%0d got addr=%h want %h", k, adr_log[k+1], 17'(17'h1FFF0 + 4*k));
            end
        end
        vectors++; if (rv_log[6] !== 1'b1 || rd_log[6] !== line_of(17'h1FFF0)) begin miscompares++; $display("FAIL wrap_resp got rv=%b rdata=%h want 1/%h", rv_log[6], rd_log[6], line_of(17'h1FFF0)); end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 17'h0;
        @(negedge clk);
        vectors++; if (req_ready !== 1'b1 || vis_signal !== MEM_NOP) begin miscompares++; $display("FAIL b2b_idle got rdy=%b sig=%b want 1/00", req_ready, vis_signal); end
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if (vis_signal !== MEM_READ_BURST || vis_addr !== 17'h0) begin miscompares++; $display("FAIL b2b_accept got sig=%b addr=%h want 10/0", vis_signal, vis_addr); end
        repeat (5) @(negedge clk);
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== line_of(17'h0)) begin miscompares++; $display("FAIL b2b_resp got rv=%b rdata=%h want 1/%h", resp_valid, resp_rdata, line_of(17'h0)); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst;
        int pulses = 0;
        run_txn(1'b0, 1'b0, 17'h00500, 17'h0, 128'h0, 1'b0, 3);
        vectors++; if (sig_log[3] !== MEM_READ_BURST || adr_log[3] !== 17'h508) begin miscompares++; $display("FAIL mid_beat2 got sig=%b addr=%h want 10/508", sig_log[3], adr_log[3]); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++; if (vis_signal !== MEM_NOP || vis_addr !== 17'h0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset got sig=%b addr=%h rdy=%b rv=%b want 00/0/1/0", vis_signal, vis_addr, req_ready, resp_valid);
        end
        vectors++; if (resp_rdata !== 128'd0) begin miscompares++; $display("FAIL mid_reset_rdata got %h want 0", resp_rdata); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pulses += int'(resp_valid);
        end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL mid_no_resp got %0d pulses want 0", pulses); end
        run_txn(1'b0, 1'b0, 17'h00500, 17'h0, 128'h0, 1'b0, 8);
        vectors++; if (rv_log[6] !== 1'b1 || rd_log[6] !== line_of(17'h500)) begin miscompares++; $display("FAIL mid_refill got rv=%b rdata=%h want 1/%h", rv_log[6], rd_log[6], line_of(17'h500)); end
    endtask

    task automatic test_held_valid;
        int pulses = 0;
        run_txn(1'b0, 1'b0, 17'h00600, 17'h0, 128'h0, 1'b1, 14);
        for (int i = 1; i <= 14; i++) pulses += int'(rv_log[i]);
        vectors++; if (pulses != 2 || rv_log[6] !== 1'b1 || rv_log[13] !== 1'b1) begin miscompares++; $display("FAIL held_pulses got %0d rv6=%b rv13=%b want 2/1/1", pulses, rv_log[6], rv_log[13]); end
        vectors++; if (rdy_log[7] !== 1'b1 || rdy_log[8] !== 1'b0 || sig_log[8] !== MEM_READ_BURST) begin miscompares++; $display("FAIL held_reaccept got rdy7=%b rdy8=%b sig8=%b want 1/0/10", rdy_log[7], rdy_log[8], sig_log[8]); end
        vectors++; if (sig_log[7] !== MEM_NOP || adr_log[8] !== 17'h600) begin miscompares++; $display("FAIL held_second got sig7=%b addr8=%h want 00/600", sig_log[7], adr_log[8]); end
        repeat (8) @(negedge clk);
        vectors++; if (req_ready !== 1'b1 || vis_signal !== MEM_NOP) begin miscompares++; $display("FAIL held_settle got rdy=%b sig=%b want 1/00", req_ready, vis_signal); end
    endtask

    initial begin
        test_reset;
        test_refill;
        test_write_only;
        test_wb_refill;
        test_back_to_back;
        test_reset_mid_burst;
        test_held_valid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
